// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO of any depth >= 2, with registered flags,
// an occupancy count and overflow/underflow pulses.
//
// Optional build macro: SYNC_FIFO_FWFT_EN selects first-word-fall-through reads.
// When it is undefined, rd_data is loaded only on an accepted read.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   wr_en       write request;  wr_data  write word
//   rd_en       read/pop request
//   rd_data     read word (registered)
//   full        count == FIFO_DEPTH
//   empty       count == 0
//   afull       count >= FIFO_AFULL
//   aempty      count <= FIFO_AEMPTY
//   data_count  words held
//   overflow    one-cycle pulse after wr_en while full
//   underflow   one-cycle pulse after rd_en while empty
module sync_fifo_param #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned FIFO_AFULL  = FIFO_DEPTH - 1,
    parameter int unsigned FIFO_AEMPTY = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               wr_en,
    input  logic [DATA_WIDTH-1:0]              wr_data,
    input  logic                               rd_en,
    output logic [DATA_WIDTH-1:0]              rd_data,
    output logic                               full,
    output logic                               empty,
    output logic                               afull,
    output logic                               aempty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    data_count,
    output logic                               overflow,
    output logic                               underflow
);

    localparam int unsigned ADDR_WIDTH = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_WIDTH  = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FIFO_DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]  count_q,  count_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic full_q,  full_d;
    logic empty_q, empty_d;
    logic afull_q, afull_d;
    logic aempty_q, aempty_d;
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    logic wr_vld_c;
    logic rd_vld_c;

    // Pointer advance with explicit wrap so non-power-of-two depths work.
    function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
        return (p == LAST_ADDR) ? '0 : p + ADDR_WIDTH'(1);
    endfunction

    // Accepted operations use the flags registered before this edge.
    assign wr_vld_c = wr_en & ~full_q;
    assign rd_vld_c = rd_en & ~empty_q;

    // Next-state for pointers, count, flags, pulses and read data.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rd_data_d   = rd_data_q;
        overflow_d  = wr_en & full_q;
        underflow_d = rd_en & empty_q;

        if (wr_vld_c) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (rd_vld_c) rd_ptr_d = ptr_inc(rd_ptr_q);

        case ({wr_vld_c, rd_vld_c})
            2'b10:   count_d = count_q + CNT_WIDTH'(1);
            2'b01:   count_d = count_q - CNT_WIDTH'(1);
            default: count_d = count_q;
        endcase

        // Flags come from the next count so they are exact after every edge.
        full_d   = (count_d == CNT_WIDTH'(FIFO_DEPTH));
        empty_d  = (count_d == '0);
        afull_d  = (count_d >= CNT_WIDTH'(FIFO_AFULL));
        aempty_d = (count_d <= CNT_WIDTH'(FIFO_AEMPTY));

`ifdef SYNC_FIFO_FWFT_EN
        // Present the next head; bypass wr_data when the head is being written now.
        if (count_d != '0) begin
            rd_data_d = (wr_vld_c && (wr_ptr_q == rd_ptr_d)) ? wr_data : mem_q[rd_ptr_d];
        end
`else
        if (rd_vld_c) rd_data_d = mem_q[rd_ptr_q];
`endif
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_data_q   <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            afull_q     <= 1'b0;
            aempty_q    <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_data_q   <= rd_data_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            afull_q     <= afull_d;
            aempty_q    <= aempty_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array, not reset.
    always_ff @(posedge clk) begin
        if (wr_vld_c && !rst) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data    = rd_data_q;
    assign full       = full_q;
    assign empty      = empty_q;
    assign afull      = afull_q;
    assign aempty     = aempty_q;
    assign data_count = count_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: three instances share one stimulus
// stream (default depth 16, depth 5, and depth 16 with thresholds 12/3).
module tb_sync_fifo_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] wr_data;

    logic [7:0] a_rd_data, b_rd_data, t_rd_data;
    logic       a_full, a_empty, a_afull, a_aempty, a_ovf, a_udf;
    logic       b_full, b_empty, b_afull, b_aempty, b_ovf, b_udf;
    logic       t_full, t_empty, t_afull, t_aempty, t_ovf, t_udf;
    logic [4:0] a_cnt, t_cnt;
    logic [2:0] b_cnt;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] q5[$];
    logic [7:0] exp_rd5;
    logic [7:0] exp_rd;

    sync_fifo_param u_d16 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(a_rd_data), .full(a_full), .empty(a_empty), .afull(a_afull),
        .aempty(a_aempty), .data_count(a_cnt), .overflow(a_ovf), .underflow(a_udf)
    );

    sync_fifo_param #(.FIFO_DEPTH(5)) u_d5 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(b_rd_data), .full(b_full), .empty(b_empty), .afull(b_afull),
        .aempty(b_aempty), .data_count(b_cnt), .overflow(b_ovf), .underflow(b_udf)
    );

    sync_fifo_param #(.FIFO_AFULL(12), .FIFO_AEMPTY(3)) u_thr (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(t_rd_data), .full(t_full), .empty(t_empty), .afull(t_afull),
        .aempty(t_aempty), .data_count(t_cnt), .overflow(t_ovf), .underflow(t_udf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count and flags of both depth-16 instances for an expected count n.
    task automatic chk_flags(input string tag, input int n);
        chk({tag, ".cnt"},     32'(a_cnt),    32'(n));
        chk({tag, ".full"},    32'(a_full),   32'(n == 16));
        chk({tag, ".empty"},   32'(a_empty),  32'(n == 0));
        chk({tag, ".afull"},   32'(a_afull),  32'(n >= 15));
        chk({tag, ".aempty"},  32'(a_aempty), 32'(n <= 1));
        chk({tag, ".t_cnt"},   32'(t_cnt),    32'(n));
        chk({tag, ".t_afull"}, 32'(t_afull),  32'(n >= 12));
        chk({tag, ".t_aempty"},32'(t_aempty), 32'(n <= 3));
    endtask

    // One cycle on the depth-5 instance, checked against a queue model.
    task automatic step5(input logic we, input logic re, input logic [7:0] d, input string tag);
        logic exp_ovf, exp_udf, do_wr, do_rd;
        logic [7:0] popped;
        exp_ovf = we && (q5.size() == 5);
        exp_udf = re && (q5.size() == 0);
        do_wr   = we && (q5.size() != 5);
        do_rd   = re && (q5.size() != 0);
        wr_en = we; rd_en = re; wr_data = d;
        if (do_rd) begin
            popped = q5.pop_front();
`ifndef SYNC_FIFO_FWFT_EN
            exp_rd5 = popped;
`endif
        end
        if (do_wr) q5.push_back(d);
        tick();
`ifdef SYNC_FIFO_FWFT_EN
        if (q5.size() != 0) exp_rd5 = q5[0];
`endif
        chk({tag, ".cnt"},    32'(b_cnt),     32'(q5.size()));
        chk({tag, ".full"},   32'(b_full),    32'(q5.size() == 5));
        chk({tag, ".empty"},  32'(b_empty),   32'(q5.size() == 0));
        chk({tag, ".afull"},  32'(b_afull),   32'(q5.size() >= 4));
        chk({tag, ".aempty"}, 32'(b_aempty),  32'(q5.size() <= 1));
        chk({tag, ".ovf"},    32'(b_ovf),     32'(exp_ovf));
        chk({tag, ".udf"},    32'(b_udf),     32'(exp_udf));
        chk({tag, ".rd"},     32'(b_rd_data), 32'(exp_rd5));
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        chk_flags("reset", 0);
        chk("reset.rd",  32'(a_rd_data), 32'h0);
        chk("reset.ovf", 32'(a_ovf), 32'h0);
        chk("reset.udf", 32'(a_udf), 32'h0);
        chk("reset.b_empty", 32'(b_empty), 32'h1);

        // Fill 0x00..0x0F (threshold sweep upward)
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            tick();
            chk_flags($sformatf("fill%0d", i), i + 1);
            chk($sformatf("fill%0d.rd", i),  32'(a_rd_data), 32'h0);
            chk($sformatf("fill%0d.ovf", i), 32'(a_ovf), 32'h0);
        end

        // Write + read while full: read wins, write dropped, overflow pulse
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hEE;
        tick();
`ifdef SYNC_FIFO_FWFT_EN
        exp_rd = 8'h01;
`else
        exp_rd = 8'h00;
`endif
        chk_flags("ovf", 15);
        chk("ovf.pulse",   32'(a_ovf), 32'h1);
        chk("ovf.t_pulse", 32'(t_ovf), 32'h1);
        chk("ovf.udf",     32'(a_udf), 32'h0);
        chk("ovf.rd",      32'(a_rd_data), 32'(exp_rd));
        wr_en = 1'b0; rd_en = 1'b0;
        tick();
        chk_flags("ovf.idle", 15);
        chk("ovf.idle.pulse", 32'(a_ovf), 32'h0);
        chk("ovf.idle.rd",    32'(a_rd_data), 32'(exp_rd));

        // Drain 0x01..0x0F (threshold sweep downward)
        for (int i = 1; i < 16; i++) begin
            rd_en = 1'b1;
            tick();
`ifdef SYNC_FIFO_FWFT_EN
            exp_rd = (i < 15) ? 8'(i + 1) : 8'h0F;
`else
            exp_rd = 8'(i);
`endif
            chk_flags($sformatf("drain%0d", i), 15 - i);
            chk($sformatf("drain%0d.rd", i),   32'(a_rd_data), 32'(exp_rd));
            chk($sformatf("drain%0d.t_rd", i), 32'(t_rd_data), 32'(exp_rd));
        end
        rd_en = 1'b0;

        // Write + read while empty: write accepted, underflow pulse
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h77;
        tick();
`ifdef SYNC_FIFO_FWFT_EN
        exp_rd = 8'h77;
`else
        exp_rd = 8'h0F;
`endif
        chk_flags("udf", 1);
        chk("udf.pulse",   32'(a_udf), 32'h1);
        chk("udf.t_pulse", 32'(t_udf), 32'h1);
        chk("udf.ovf",     32'(a_ovf), 32'h0);
        chk("udf.rd",      32'(a_rd_data), 32'(exp_rd));
        wr_en = 1'b0; rd_en = 1'b0;
        tick();
        chk("udf.idle.pulse", 32'(a_udf), 32'h0);
        rd_en = 1'b1;
        tick();
        chk_flags("udf.pop", 0);
        chk("udf.pop.rd", 32'(a_rd_data), 32'h77);
        // Read while empty alone: rejected, data held
        tick();
        chk("udf2.pulse", 32'(a_udf), 32'h1);
        chk("udf2.rd",    32'(a_rd_data), 32'h77);
        chk_flags("udf2", 0);
        rd_en = 1'b0;
        tick();
        chk("udf2.idle.pulse", 32'(a_udf), 32'h0);

        // Write into empty FIFO, then pop with a simultaneous write
        wr_en = 1'b1; wr_data = 8'hA5;
        tick();
`ifdef SYNC_FIFO_FWFT_EN
        exp_rd = 8'hA5;
`else
        exp_rd = 8'h77;
`endif
        chk("wa5.empty", 32'(a_empty), 32'h0);
        chk("wa5.rd",    32'(a_rd_data), 32'(exp_rd));
        rd_en = 1'b1; wr_data = 8'h3C;
        tick();
`ifdef SYNC_FIFO_FWFT_EN
        exp_rd = 8'h3C;
`else
        exp_rd = 8'hA5;
`endif
        chk_flags("pw3c", 1);
        chk("pw3c.rd",  32'(a_rd_data), 32'(exp_rd));
        chk("pw3c.ovf", 32'(a_ovf), 32'h0);
        chk("pw3c.udf", 32'(a_udf), 32'h0);
        wr_en = 1'b0;
        tick();
        chk_flags("p3c", 0);
        chk("p3c.rd", 32'(a_rd_data), 32'h3C);
        rd_en = 1'b0;

        // Mid-run reset with 7 words held and wr_en high
        for (int i = 0; i < 7; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h10 + i);
            tick();
        end
        chk("pre_rst.cnt", 32'(a_cnt), 32'd7);
        rst = 1'b1; wr_data = 8'h99;
        tick();
        rst = 1'b0; wr_en = 1'b0;
        chk_flags("mrst", 0);
        chk("mrst.rd",  32'(a_rd_data), 32'h0);
        chk("mrst.ovf", 32'(a_ovf), 32'h0);
        chk("mrst.udf", 32'(a_udf), 32'h0);
        tick();
        chk_flags("mrst.idle", 0);
        chk("mrst.idle.ovf", 32'(a_ovf), 32'h0);
        chk("mrst.idle.udf", 32'(a_udf), 32'h0);
        wr_en = 1'b1; wr_data = 8'h42;
        tick();
        wr_en = 1'b0; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk_flags("mrst.wr", 0);
        chk("mrst.wr.rd", 32'(a_rd_data), 32'h42);

        // Depth 5: write 5 / read 3 over 4 rounds, pointers wrap
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_rd5 = 8'h00;
        chk("d5.reset.cnt", 32'(b_cnt), 32'h0);
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 5; k++) step5(1'b1, 1'b0, 8'(r * 16 + k), $sformatf("d5.r%0d.w%0d", r, k));
            for (int k = 0; k < 3; k++) step5(1'b0, 1'b1, 8'h00, $sformatf("d5.r%0d.r%0d", r, k));
        end
        for (int k = 0; k < 3; k++) step5(1'b0, 1'b1, 8'h00, $sformatf("d5.drain%0d", k));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Single-clock, parametrised FIFO for buffering data between producer and consumer logic that share one clock domain. It takes over the storage, pointer and flag role of the dual-clock FIFO for same-domain paths, and adds:
- any depth, not only powers of two;
- an occupancy count output;
- overflow and underflow pulses;
- an optional first-word-fall-through read mode.

## Interface
Parameters:
- DATA_WIDTH, 8, width of each word.
- FIFO_DEPTH, 16, number of words stored; any integer ≥ 2.
- FIFO_AFULL, FIFO_DEPTH-1, afull threshold; legal range 1..FIFO_DEPTH.
- FIFO_AEMPTY, 1, aempty threshold; legal range 0..FIFO_DEPTH-1.

Local parameters:
- ADDR_WIDTH = $clog2(FIFO_DEPTH).
- CNT_WIDTH = $clog2(FIFO_DEPTH+1).

Ports:
- clk  input  1  the only clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  write request.
- wr_data  input  DATA_WIDTH  write word.
- rd_en  input  1  read/pop request.
- rd_data  output  DATA_WIDTH  read word; registered.
- full  output  1  count == FIFO_DEPTH; registered.
- empty  output  1  count == 0; registered.
- afull  output  1  count ≥ FIFO_AFULL; registered.
- aempty  output  1  count ≤ FIFO_AEMPTY; registered.
- data_count  output  CNT_WIDTH  number of words held; registered.
- overflow  output  1  one-cycle pulse: wr_en was asserted while full.
- underflow  output  1  one-cycle pulse: rd_en was asserted while empty.

## Operation
- Accepted operations:
  - wr_vld = wr_en & ~full.
  - rd_vld = rd_en & ~empty.
  - Both use the registered flags from before the current edge.
- Pointers:
  - wr_ptr and rd_ptr are ADDR_WIDTH bits wide.
  - Each advances by 1 on its valid operation and wraps from FIFO_DEPTH-1 to 0. This holds for non-power-of-2 depths.
- data_count:
  - Next value is count + wr_vld - rd_vld.
  - A simultaneous accepted read and write leaves it unchanged.
  - It never exceeds FIFO_DEPTH and never goes below 0.
- Flags full, empty, afull and aempty are computed from the next count and registered, so they are exact in the cycle after every edge.
- Full with wr_en and rd_en both high:
  - The read is accepted and the write is dropped.
  - overflow pulses; count goes to FIFO_DEPTH-1.
- Empty with wr_en and rd_en both high:
  - The write is accepted and the read is rejected.
  - underflow pulses; count goes to 1.
- Dropped writes do not change memory or pointers. Rejected reads do not change rd_data (standard mode) or pointers.
- Reset values:
  - wr_ptr = rd_ptr = 0, data_count = 0.
  - empty = 1, aempty = 1, full = 0, afull = 0.
  - rd_data = 0, overflow = underflow = 0.
  - Memory contents are not reset.
- Reset mid-operation discards all stored words. wr_en and rd_en in the reset cycle are ignored and raise no pulses.

## Timing
- Write: a word presented with wr_vld at edge N is stored at edge N. After N, empty = 0 and data_count reflects it.
- Standard-mode read:
  - rd_vld at edge M loads mem[rd_ptr] into rd_data at edge M, so the data is valid in the cycle after M (1-cycle latency).
  - rd_data holds its value otherwise.
- Read of a word written at the same edge is impossible, because empty blocks it.
- overflow and underflow are registered: they are high for exactly the one cycle after the offending edge.
- No combinational path exists from any input to any output.

## Configuration
- Macro SYNC_FIFO_FWFT_EN.
- Undefined (standard mode): rd_data updates only on rd_vld, per Timing.
- Defined (first-word fall-through):
  - rd_data always shows the head word whenever empty = 0; rd_vld pops it.
  - The next word appears on rd_data in the cycle after the pop edge. If the pop empties the FIFO, rd_data holds the last value.
  - A write into an empty FIFO at edge N shows that word on rd_data, with empty = 0, in the cycle after N.
  - The case count == 1 with a simultaneous pop and write at edge N presents the new word after N.
  - data_count includes the head word. Flag definitions are unchanged.
  - rd_data resets to 0.

## Test plan
- Fill and drain, DEPTH=16, WIDTH=8:
  - Write 0x00..0x0F -> full = 1 after the 16th write, afull = 1 from count 15, data_count = 16.
  - Then read 16 -> rd_data = 0x00..0x0F in order, one cycle after each rd_en; empty = 1 after the last read.
- Non-power-of-2 DEPTH=5:
  - Write 5 and read 3, repeated over 4 rounds -> no data loss or reordering across pointer wrap; full asserts at count 5 only.
- Boundaries:
  - wr_en + rd_en while full -> count 16→15, the oldest word is read, overflow pulses for 1 cycle.
  - wr_en + rd_en while empty -> count 0→1, underflow pulses for 1 cycle, rd_data unchanged.
- Mid-run reset:
  - rst for 1 cycle with 7 words held and wr_en high -> after reset data_count = 0, empty = 1, aempty = 1, rd_data = 0, no overflow or underflow pulse.
- Thresholds FIFO_AFULL=12, FIFO_AEMPTY=3:
  - Sweep count 0..16..0 -> afull exactly for count ≥ 12, aempty exactly for count ≤ 3, with the flags changing on the same edge as the count.
- FWFT build:
  - Write 0xA5 into an empty FIFO -> rd_data = 0xA5 and empty = 0 in the next cycle, without rd_en.
  - Pop, with 0x3C written at the same edge -> rd_data = 0x3C next cycle, data_count remains 1.
